mtr_ovr_i_prot: RTL and testbench

//  Parametrised over-current protection for NUM_CH motor bridges; generalises the mtr_drv blanking check.

---
 rtl/mtr_prot_pkg.sv | 26 ++
 rtl/ovr_i_ch.sv | 132 +++++++++++++
 rtl/mtr_ovr_i_prot.sv | 80 ++++++++
 tb/tb_mtr_ovr_i_prot.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mtr_prot_pkg.sv
// Shared types and defaults for the motor over-current protection block.
package mtr_prot_pkg;

    // Per-channel protection state, held in 2 bits
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MON   = 2'd1,
        FAULT = 2'd2
    } ch_state_t;

    localparam int unsigned DEF_NUM_CH        = 2;
    localparam int unsigned DEF_CYC_W         = 11;
    localparam int unsigned DEF_BLANK_CYC     = 128;
    localparam int unsigned DEF_WIN_CYC       = 128;
    localparam int unsigned DEF_FAULT_THRESH  = 40;
    localparam int unsigned DEF_LATCH_MODE    = 1;
    localparam int unsigned DEF_RETRY_PERIODS = 1024;

    localparam int unsigned PRD_CNT_W = 8;

    // Saturating increment for the consecutive-fault period counter
    function automatic logic [PRD_CNT_W-1:0] prd_sat_inc(input logic [PRD_CNT_W-1:0] v);
        return (v == '1) ? v : v + PRD_CNT_W'(1);
    endfunction

endpackage

// File: rtl/ovr_i_ch.sv
// One over-current channel: input synchroniser, window hit flag,
// consecutive faulted-period counter, retry counter and protection FSM.
module ovr_i_ch
    import mtr_prot_pkg::*;
#(
    parameter int unsigned FAULT_THRESH  = DEF_FAULT_THRESH,
    parameter int unsigned LATCH_MODE    = DEF_LATCH_MODE,
    parameter int unsigned RETRY_PERIODS = DEF_RETRY_PERIODS
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pwm_sync,
    input  logic win_vld,
    input  logic clr_fault,
    input  logic ovr_i,
    output logic fault
);

    localparam int unsigned RETRY_W = $clog2(RETRY_PERIODS + 1);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_MON   = MON;
    localparam logic [1:0] ST_FAULT = FAULT;

    logic                 ovr_meta;
    logic                 ovr_sync;
    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic                 hit;
    logic                 hit_nxt;
    logic [PRD_CNT_W-1:0] prd_cnt;
    logic [PRD_CNT_W-1:0] prd_nxt;
    logic [RETRY_W-1:0]   retry_cnt;
    logic [RETRY_W-1:0]   retry_nxt;
    logic [RETRY_W-1:0]   retry_inc_c;
    logic                 fault_nxt;

    // Two-flop synchroniser for the asynchronous bridge flag
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovr_meta <= 1'b0;
            ovr_sync <= 1'b0;
        end else begin
            ovr_meta <= ovr_i;
            ovr_sync <= ovr_meta;
        end
    end

    // Protection state and counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            hit       <= 1'b0;
            prd_cnt   <= '0;
            retry_cnt <= '0;
            fault     <= 1'b0;
        end else begin
            state     <= state_nxt;
            hit       <= hit_nxt;
            prd_cnt   <= prd_nxt;
            retry_cnt <= retry_nxt;
            fault     <= fault_nxt;
        end
    end

    // Next-state logic; clr_fault overrides everything, including a trip in the same cycle
    always_comb begin
        state_nxt   = state;
        hit_nxt     = hit;
        prd_nxt     = prd_cnt;
        retry_nxt   = retry_cnt;
        fault_nxt   = fault;
        retry_inc_c = retry_cnt + RETRY_W'(1);

        if (clr_fault) begin
            state_nxt = ST_MON;
            hit_nxt   = 1'b0;
            prd_nxt   = '0;
            retry_nxt = '0;
            fault_nxt = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (pwm_sync) begin
                        state_nxt = ST_MON;
                        hit_nxt   = 1'b0;
                        prd_nxt   = '0;
                    end
                end
                ST_MON: begin
                    if (pwm_sync) begin
                        hit_nxt = 1'b0;
                        if (hit) begin
                            prd_nxt = prd_sat_inc(prd_cnt);
                            if (prd_nxt >= PRD_CNT_W'(FAULT_THRESH)) begin
                                state_nxt = ST_FAULT;
                                retry_nxt = '0;
                                fault_nxt = 1'b1;
                            end
                        end else begin
                            prd_nxt = '0;
                        end
                    end else if (win_vld && ovr_sync) begin
                        hit_nxt = 1'b1;
                    end
                end
                ST_FAULT: begin
                    hit_nxt   = 1'b0;
                    fault_nxt = 1'b1;
                    if ((LATCH_MODE == 0) && pwm_sync) begin
                        if (retry_inc_c >= RETRY_W'(RETRY_PERIODS)) begin
                            state_nxt = ST_MON;
                            prd_nxt   = '0;
                            retry_nxt = '0;
                            fault_nxt = 1'b0;
                        end else begin
                            retry_nxt = retry_inc_c;
                        end
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    hit_nxt   = 1'b0;
                    prd_nxt   = '0;
                    retry_nxt = '0;
                    fault_nxt = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/mtr_ovr_i_prot.sv
// Over-current protection for NUM_CH motor bridges: shared in-period cycle
// counter and sample-window decode, per-channel monitors, registered shutdown.
module mtr_ovr_i_prot
    import mtr_prot_pkg::*;
#(
    parameter int unsigned NUM_CH        = DEF_NUM_CH,
    parameter int unsigned CYC_W         = DEF_CYC_W,
    parameter int unsigned BLANK_CYC     = DEF_BLANK_CYC,
    parameter int unsigned WIN_CYC       = DEF_WIN_CYC,
    parameter int unsigned FAULT_THRESH  = DEF_FAULT_THRESH,
    parameter int unsigned LATCH_MODE    = DEF_LATCH_MODE,
    parameter int unsigned RETRY_PERIODS = DEF_RETRY_PERIODS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              PWM_sync,
    input  logic [NUM_CH-1:0] OVR_I,
    input  logic              clr_fault,
    output logic [NUM_CH-1:0] fault_ch,
    output logic              OVR_I_shtdwn
);

    // One extra bit so BLANK_CYC+WIN_CYC is representable
    localparam int unsigned CMP_W = CYC_W + 1;
    localparam logic [CMP_W-1:0] WIN_LO = CMP_W'(BLANK_CYC);
    localparam logic [CMP_W-1:0] WIN_HI = CMP_W'(BLANK_CYC + WIN_CYC);

    if ((64'(BLANK_CYC) + 64'(WIN_CYC)) > (64'(1) << CYC_W)) begin : g_bad_window
        $error("mtr_ovr_i_prot: BLANK_CYC+WIN_CYC exceeds the cycle counter range");
    end
    if ((FAULT_THRESH < 1) || (FAULT_THRESH > 255)) begin : g_bad_thresh
        $error("mtr_ovr_i_prot: FAULT_THRESH must be in 1..255");
    end

    logic [CYC_W-1:0] cyc_cnt;
    logic             win_vld_c;

    // In-period cycle counter: restarts after PWM_sync, saturates instead of wrapping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cyc_cnt <= '0;
        end else if (PWM_sync) begin
            cyc_cnt <= '0;
        end else if (cyc_cnt != '1) begin
            cyc_cnt <= cyc_cnt + CYC_W'(1);
        end
    end

    // Sample window after switching blanking; the PWM_sync cycle itself never samples
    assign win_vld_c = !PWM_sync
                     && ({1'b0, cyc_cnt} >= WIN_LO)
                     && ({1'b0, cyc_cnt} <  WIN_HI);

    // Independent per-channel monitors
    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        ovr_i_ch #(
            .FAULT_THRESH  (FAULT_THRESH),
            .LATCH_MODE    (LATCH_MODE),
            .RETRY_PERIODS (RETRY_PERIODS)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .pwm_sync  (PWM_sync),
            .win_vld   (win_vld_c),
            .clr_fault (clr_fault),
            .ovr_i     (OVR_I[ch]),
            .fault     (fault_ch[ch])
        );
    end

    // Registered bridge shutdown, one clk behind fault_ch
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            OVR_I_shtdwn <= 1'b0;
        end else begin
            OVR_I_shtdwn <= |fault_ch;
        end
    end

endmodule

// File: tb/tb_mtr_ovr_i_prot.sv
// Directed bench: latched instance (defaults) and auto-retry instance
// (LATCH_MODE=0, RETRY_PERIODS=4) share clk, PWM_sync, clr_fault and rst_n.
module tb_mtr_ovr_i_prot;

    localparam int P = 280;   // PWM period in clks (window ends at cyc 255)

    logic       clk;
    logic       rst_n;
    logic       pwm_sync;
    logic       clr_fault;
    logic [1:0] ovr_m;
    logic [1:0] ovr_r;
    logic [1:0] fault_m;
    logic [1:0] fault_r;
    logic       sh_m;
    logic       sh_r;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mtr_ovr_i_prot u_dut_m (
        .clk          (clk),
        .rst_n        (rst_n),
        .PWM_sync     (pwm_sync),
        .OVR_I        (ovr_m),
        .clr_fault    (clr_fault),
        .fault_ch     (fault_m),
        .OVR_I_shtdwn (sh_m)
    );

    mtr_ovr_i_prot #(
        .LATCH_MODE    (0),
        .RETRY_PERIODS (4)
    ) u_dut_r (
        .clk          (clk),
        .rst_n        (rst_n),
        .PWM_sync     (pwm_sync),
        .OVR_I        (ovr_r),
        .clr_fault    (clr_fault),
        .fault_ch     (fault_r),
        .OVR_I_shtdwn (sh_r)
    );

    typedef struct packed {
        logic [1:0] fm;
        logic       sm;
        logic [1:0] fr;
        logic       sr;
    } obs_t;

    typedef struct {
        string tag;
        obs_t  val;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int unsigned mode_m [2];
    int unsigned mode_r [2];
    logic [1:0]  prev_m;
    logic [1:0]  prev_r;

    // Raw OVR_I shape per period; k = cyc_cnt in the cycle it is driven (-1 = sync cycle).
    // Sampled value reaches the window logic 2 clks later.
    function automatic logic ovr_bit(input int unsigned mode, input int k);
        case (mode)
            1:       return 1'b1;                      // continuous
            2:       return (k >= 10) && (k <= 125);   // blanked: seen at cyc 12..127
            3:       return k == 126;                  // seen at cyc 128, first window clk
            4:       return k == 254;                  // seen at cyc 256, just past window
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive_ovr(input int k);
        ovr_m = {ovr_bit(mode_m[1], k), ovr_bit(mode_m[0], k)};
        ovr_r = {ovr_bit(mode_r[1], k), ovr_bit(mode_r[0], k)};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [1:0] fm, input logic sm,
                        input logic [1:0] fr, input logic sr);
        exp_t e;
        e.tag = tag;
        e.val = {fm, sm, fr, sr};
        sb.push_back(e);
    endtask

    task automatic check();
        exp_t e;
        obs_t o;
        e = sb.pop_front();
        o = {fault_m, sh_m, fault_r, sh_r};
        n_cmp++;
        assert (o === e.val) else begin
            n_err++;
            $error("FAIL %s: observed {fm,sm,fr,sr}=%b expected %b", e.tag, o, e.val);
        end
    endtask

    // Expectations around one sync: A right after the sync edge (shutdown still
    // reflects the previous fault), B one clk later (shutdown caught up)
    task automatic push_period(input string tag, input logic [1:0] fm, input logic [1:0] fr);
        push($sformatf("%s A", tag), fm, |prev_m, fr, |prev_r);
        push($sformatf("%s B", tag), fm, |fm, fr, |fr);
        prev_m = fm;
        prev_r = fr;
    endtask

    task automatic run_cycles(input int k0, input int k1);
        for (int k = k0; k < k1; k++) begin
            drive_ovr(k);
            tick();
        end
    endtask

    task automatic run_period(input int ncyc, input logic clr);
        pwm_sync  = 1'b1;
        clr_fault = clr;
        drive_ovr(-1);
        tick();
        pwm_sync  = 1'b0;
        clr_fault = 1'b0;
        check();
        for (int k = 0; k < ncyc; k++) begin
            drive_ovr(k);
            tick();
            if (k == 0) check();
        end
    endtask

    initial begin
        logic [1:0] fm;
        logic [1:0] fr;

        rst_n     = 1'b0;
        pwm_sync  = 1'b0;
        clr_fault = 1'b0;
        mode_m[0] = 1;  mode_m[1] = 0;
        mode_r[0] = 1;  mode_r[1] = 0;
        prev_m    = 2'b00;
        prev_r    = 2'b00;
        drive_ovr(0);
        tick();
        tick();
        push("reset", 2'b00, 1'b0, 2'b00, 1'b0);
        check();
        rst_n = 1'b1;
        run_cycles(0, 20);

        // OVR_I[0] held high: latched trips at sync 41; retry trips 41, clears 45, re-trips 85.
        // From sync 86 input is clean: latched fault must hold.
        for (int s = 1; s <= 95; s++) begin
            if (s == 86) begin
                mode_m[0] = 0;
                mode_r[0] = 0;
            end
            fm = (s >= 41) ? 2'b01 : 2'b00;
            fr = (((s >= 41) && (s <= 44)) || ((s >= 85) && (s <= 88))) ? 2'b01 : 2'b00;
            push_period($sformatf("trip s%0d", s), fm, fr);
            run_period((s == 95) ? 50 : P - 1, 1'b0);
        end

        // clr_fault mid-period releases the latched fault on the next clk
        clr_fault = 1'b1;
        drive_ovr(50);
        tick();
        clr_fault = 1'b0;
        push("clr fault_ch", 2'b00, 1'b1, 2'b00, 1'b0);
        check();
        drive_ovr(51);
        tick();
        push("clr shtdwn", 2'b00, 1'b0, 2'b00, 1'b0);
        check();
        run_cycles(52, P - 1);
        prev_m = 2'b00;
        prev_r = 2'b00;

        // ch0: 39 window hits, a period with a pulse just past the window, 39 hits,
        // same gap, then 40 hits -> trip at sync 121. ch1: blanked pulses for 80
        // periods then 40 window hits -> simultaneous trip at sync 121.
        for (int c = 1; c <= 121; c++) begin
            mode_m[0] = ((c == 40) || (c == 80)) ? 4 : 3;
            mode_m[1] = (c <= 80) ? 2 : 3;
            fm = (c >= 121) ? 2'b11 : 2'b00;
            push_period($sformatf("window c%0d", c), fm, 2'b00);
            run_period((c == 121) ? 40 : P - 1, 1'b0);
        end

        // Reset one clk in the middle of FAULT
        rst_n = 1'b0;
        drive_ovr(40);
        tick();
        push("reset mid-fault", 2'b00, 1'b0, 2'b00, 1'b0);
        check();
        rst_n     = 1'b1;
        mode_m[0] = 1;
        mode_m[1] = 0;
        run_cycles(41, P - 1);
        prev_m = 2'b00;
        prev_r = 2'b00;

        // After reset: IDLE until first sync, then 39 counted hits; clr_fault on the
        // sync that would reach the threshold must prevent the trip
        for (int r = 1; r <= 42; r++) begin
            push_period($sformatf("idle/clr r%0d", r), 2'b00, 2'b00);
            run_period(P - 1, r == 41);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
